// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared types for the MIPS core memory port
package mips_cpu_pkg;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} mem_size_t;

  typedef enum logic [1:0] {IDLE, REQ, RESP} mem_port_state_t;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_low_mask(input mem_size_t size);
    case (size)
      SZ_BYTE: return 3'd0;
      SZ_HALF: return 3'd1;
      SZ_WORD: return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_mem_lane.sv
// rtl/mips_cpu_mem_lane.sv - byteenable generation, store lane steering, load extract/extend
module mips_cpu_mem_lane
  import mips_cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] lane,
  input  mem_size_t                   size,
  input  logic                        is_signed,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [DATA_W-1:0]           rdata,
  output logic [DATA_W/8-1:0]         be,
  output logic [DATA_W-1:0]           wdata_lane,
  output logic [DATA_W-1:0]           rdata_ext
);

  localparam int BE_W = DATA_W / 8;

  logic [BE_W-1:0]   mask;
  logic [DATA_W-1:0] shifted;
  logic              sign;

  always_comb begin
    case (size)
      SZ_BYTE: mask = BE_W'(1);
      SZ_HALF: mask = BE_W'(3);
      SZ_WORD: mask = BE_W'(15);
      default: mask = '1;
    endcase
  end

  assign be         = mask << lane;
  assign wdata_lane = wdata << {lane, 3'b000};
  assign shifted    = rdata >> {lane, 3'b000};

  always_comb begin
    case (size)
      SZ_BYTE: sign = shifted[7];
      SZ_HALF: sign = shifted[15];
      SZ_WORD: sign = shifted[31];
      default: sign = shifted[DATA_W-1];
    endcase
  end

  // Bytes beyond the access width are filled with the sign (or zero).
  always_comb begin
    rdata_ext = '0;
    for (int i = 0; i < BE_W; i++)
      rdata_ext[8*i +: 8] = mask[i] ? shifted[8*i +: 8] : {8{sign & is_signed}};
  end

endmodule

// File: rtl/mips_cpu_mem_port.sv
// rtl/mips_cpu_mem_port.sv - Avalon-MM master port for the multicycle MIPS core
// Define MIPS_MEM_MISALIGN_TRAP_EN to trap misaligned/illegal-size requests instead of aligning them.
module mips_cpu_mem_port
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int LB   = $clog2(BE_W);

  mem_port_state_t state, state_next;
  logic            write_q, signed_q;
  mem_size_t       size_q, eff_size, size_sel;
  logic [LB-1:0]   lane_q, req_lane, lane_sel;
  logic            accept, illegal, misaligned;
  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_wdata, lane_rdata;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign illegal   = (DATA_W == 32) && (mem_size_t'(req_size) == SZ_DWORD);

`ifdef MIPS_MEM_MISALIGN_TRAP_EN
  assign eff_size   = mem_size_t'(req_size);
  assign req_lane   = req_addr[LB-1:0];
  assign misaligned = illegal || (|(req_lane & LB'(size_low_mask(eff_size))));
`else
  assign eff_size   = illegal ? SZ_WORD : mem_size_t'(req_size);
  assign req_lane   = req_addr[LB-1:0] & ~LB'(size_low_mask(eff_size));
  assign misaligned = 1'b0;
`endif

  // The lane helper serves the incoming request in IDLE and the held one in RESP.
  assign lane_sel = (state == IDLE) ? req_lane : lane_q;
  assign size_sel = (state == IDLE) ? eff_size : size_q;

  mips_cpu_mem_lane #(.DATA_W(DATA_W)) u_lane (
    .lane       (lane_sel),
    .size       (size_sel),
    .is_signed  (signed_q),
    .wdata      (req_wdata),
    .rdata      (readdata),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .rdata_ext  (lane_rdata)
  );

  assign read  = (state == REQ) && !write_q;
  assign write = (state == REQ) && write_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !misaligned) state_next = REQ;
      REQ:     if (!waitrequest) state_next = write_q ? IDLE : RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= SZ_BYTE;
      lane_q     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (misaligned) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            address    <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
            byteenable <= lane_be;
            writedata  <= lane_wdata;
            write_q    <= req_write;
            signed_q   <= req_signed;
            size_q     <= eff_size;
            lane_q     <= req_lane;
          end
        end
        REQ: if (!waitrequest && write_q) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= lane_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_port.sv
// tb/tb_mips_cpu_mem_port.sv - self-checking bench for mips_cpu_mem_port (DATA_W=32)
module tb_mips_cpu_mem_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, read, write;
  logic [31:0] rsp_rdata, address, writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_cpu_mem_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .address(address), .read(read),
    .write(write), .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata)
  );

  // Reference: bus view and response of one request, from the lane arithmetic rules.
  function automatic void model(input bit wr, input int sz, input bit sgn,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                output bit err, output logic [31:0] m_addr, output logic [3:0] m_be,
                                output logic [31:0] m_wd, output logic [31:0] m_rd);
    int nb, lane;
    longint unsigned v, lim;
    err = 0;
    if (sz == 3) begin
`ifdef MIPS_MEM_MISALIGN_TRAP_EN
      err = 1;
      nb = 8;
`else
      nb = 4;
`endif
    end else nb = 1 << sz;
`ifdef MIPS_MEM_MISALIGN_TRAP_EN
    if ((a % nb) != 0) err = 1;
    lane = int'(a % 4);
`else
    lane = int'(a % 4) / nb * nb;
`endif
    m_addr = a - (a % 4);
    m_be   = 4'(((1 << nb) - 1) << lane);
    m_wd   = 32'(longint'(wd) << (8 * lane));
    lim    = (nb >= 8) ? ~64'd0 : ((64'd1 << (8 * nb)) - 1);
    v      = (longint'(rd) >> (8 * lane)) & lim;
    if (sgn && v[8*nb-1]) v = v | ~lim;
    m_rd   = (wr || err) ? 32'd0 : v[31:0];
  endfunction

  // Issues one request in the current (IDLE) cycle and follows it to its response;
  // returns in the response cycle so the next request can start back-to-back.
  task automatic run_txn(input bit wr, input int sz, input bit sgn, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int w);
    bit err;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0]  e_be;
    model(wr, sz, sgn, a, wd, rd, err, e_addr, e_be, e_wd, e_rd);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle: got %b want 1 (addr %h)", req_ready, a);
    end
    req_valid = 1'b1; req_write = wr; req_size = 2'(sz); req_signed = sgn;
    req_addr = a; req_wdata = wd; waitrequest = 1'b1; readdata = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = $urandom; req_size = 2'($urandom);
    if (err) begin
      checks++;
      if ({rsp_valid, rsp_err, read, write} !== 4'b1100 || rsp_rdata !== 32'd0) begin
        errors++;
        $display("FAIL trap_rsp: got valid/err/read/write=%b%b%b%b rdata=%h want 1100 rdata=0 (addr %h)",
                 rsp_valid, rsp_err, read, write, rsp_rdata, a);
      end
    end else begin
      for (int k = 0; k <= w; k++) begin
        waitrequest = (k < w);
        checks++;
        if (read !== !wr || write !== wr || address !== e_addr || byteenable !== e_be ||
            (wr && writedata !== e_wd) || rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL bus_cycle%0d: got r=%b w=%b addr=%h be=%b wd=%h rv=%b want r=%b w=%b addr=%h be=%b wd=%h rv=0",
                   k, read, write, address, byteenable, writedata, rsp_valid, !wr, wr, e_addr, e_be, e_wd);
        end
        readdata = $urandom;
        @(posedge clk); #1;
      end
      waitrequest = $urandom;
      if (!wr) begin
        checks++;
        if (read !== 1'b0 || write !== 1'b0 || rsp_valid !== 1'b0) begin
          errors++; $display("FAIL resp_phase: got r=%b w=%b rv=%b want 0 0 0", read, write, rsp_valid);
        end
        readdata = rd;
        @(posedge clk); #1;
        readdata = $urandom;
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== e_rd || read !== 1'b0 || write !== 1'b0) begin
        errors++;
        $display("FAIL rsp: got rv=%b err=%b rdata=%h r=%b w=%b want rv=1 err=0 rdata=%h r=0 w=0 (addr %h)",
                 rsp_valid, rsp_err, rsp_rdata, read, write, e_rd, a);
      end
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_with_rsp: got %b want 1", req_ready);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || read !== 1'b0 || write !== 1'b0) begin
        errors++; $display("FAIL idle: got rv=%b r=%b w=%b want 0 0 0", rsp_valid, read, write);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({read, write, rsp_valid, rsp_err, req_ready} !== 5'b0 || address !== 32'd0 ||
        byteenable !== 4'd0 || writedata !== 32'd0 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: got r=%b w=%b rv=%b err=%b rdy=%b addr=%h be=%b wd=%h rd=%h want all 0",
               read, write, rsp_valid, rsp_err, req_ready, address, byteenable, writedata, rsp_rdata);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b want 1", req_ready);
    end
  endtask

  task automatic test_store;
    run_txn(1, 2, 0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0);
    idle_cycles(1);
    run_txn(1, 0, 0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0);
    idle_cycles(1);
  endtask

  task automatic test_load_ext;
    run_txn(0, 1, 1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0);
    run_txn(0, 1, 0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0);
    run_txn(0, 0, 1, 32'h0000_2001, 32'h0, 32'h1234_F600, 1);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back;
    run_txn(0, 2, 0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 3);
    run_txn(1, 1, 0, 32'h0000_3006, 32'h0000_BEEF, 32'h0, 2);
    run_txn(0, 2, 1, 32'h0000_3004, 32'h0, 32'h8765_4321, 0);
    idle_cycles(1);
  endtask

  task automatic test_misalign;
    run_txn(0, 2, 0, 32'h0000_2001, 32'h0, 32'h1122_3344, 0);
    run_txn(1, 1, 0, 32'h0000_2003, 32'h0000_5A5A, 32'h0, 0);
    run_txn(0, 3, 1, 32'h0000_2004, 32'h0, 32'h8899_AABB, 1);
    idle_cycles(1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      run_txn($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom, $urandom, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0000_4000; waitrequest = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (read !== 1'b1) begin
      errors++; $display("FAIL mid_read_start: got %b want 1", read);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (read !== 1'b0 || write !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got r=%b w=%b rv=%b rdy=%b want 0 0 0 0", read, write, rsp_valid, req_ready);
    end
    reset = 1'b0; waitrequest = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_ready: got %b want 1", req_ready);
    end
    idle_cycles(4);
    run_txn(0, 0, 1, 32'h0000_4003, 32'h0, 32'h8000_0000, 1);
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_ext();
    test_back_to_back();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_cpu_mem_port.md
# mips_cpu_mem_port

Parametrised Avalon-MM master port that sits between the multicycle MIPS core FSM and the memory bus. It replaces the core's ad-hoc read/write/address logic with a request/response handshake. It supports byte, half, word and (64-bit builds) doubleword accesses, with byte-lane steering, byteenable generation, sign/zero extension and full waitrequest stall handling. The core issues one request at a time, for fetch, load or store, and receives one response per request.

## Interface
Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, bus data width; legal values 32 or 64. BE_W = DATA_W/8 and LB = log2(BE_W) are derived.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  core has a request.
- req_ready  out  1  port can accept; high only in IDLE and not in reset.
- req_write  in  1  1 = store, 0 = load/fetch.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64).
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores.
- rsp_err  out  1  misaligned or illegal-size request.
- address  out  ADDR_W  bus address, low LB bits always 0.
- read  out  1  Avalon read request.
- write  out  1  Avalon write request.
- waitrequest  in  1  slave stall.
- writedata  out  DATA_W  lane-steered store data.
- byteenable  out  BE_W  active lanes.
- readdata  in  DATA_W  valid the cycle after a read is accepted (read=1, waitrequest=0).

## Operation
- States: IDLE, REQ, RESP.
- IDLE: accept when req_valid && req_ready. Register the address, byteenable, writedata, size and signed fields, then go to REQ. rsp_valid falls in any cycle in which it is not set.
- REQ: drive read = !write_q and write = write_q. While waitrequest=1, hold all bus outputs stable.
  - When waitrequest=0 and the access is a write: go to IDLE and set rsp_valid=1 and rsp_err=0 for the next cycle.
  - When waitrequest=0 and the access is a read: go to RESP.
- RESP: sample readdata and extract lane bytes starting at lane addr[LB-1:0].
  - Extend the result to DATA_W: sign-extend if signed_q, otherwise zero-extend.
  - Register the result into rsp_rdata, pulse rsp_valid, and go to IDLE.
- Lane rules (little-endian lane numbering):
  - size bytes = 1 << req_size.
  - byteenable = ((1 << size_bytes) - 1) << addr[LB-1:0].
  - writedata = req_wdata << (8 * addr[LB-1:0]).
  - address = {req_addr[ADDR_W-1:LB], LB zeros}.
- Illegal size (dword with DATA_W=32) is treated as misaligned.
- Back-to-back operation: req_ready is high in the same cycle as rsp_valid, so the next request can be accepted immediately.
- Reset mid-operation: on the next edge, read, write and rsp_valid are 0, the state is IDLE, and the pending response is discarded with no rsp_valid.
- Reset values: read=0, write=0, address=0, byteenable=0, writedata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 while reset is high.

## Timing
- Write accepted in cycle N: bus write in N+1..N+1+W, where W = waitrequest cycles; rsp_valid in N+2+W.
- Read accepted in cycle N: bus read in N+1..N+1+W; readdata sampled in N+2+W; rsp_valid in N+3+W.
- Misaligned request with the check compiled in: rsp_valid with rsp_err=1 in N+1; no bus cycle.
- rsp_valid is exactly one cycle wide. read and write are never high together.

## Configuration
- MIPS_MEM_MISALIGN_TRAP_EN defined: an access is misaligned when addr mod size_bytes ≠ 0 or the size is illegal.
  - Such a request is accepted but not issued to the bus.
  - rsp_err=1 and rsp_rdata=0 in N+1.
- MIPS_MEM_MISALIGN_TRAP_EN undefined:
  - The low address bits are forced aligned: addr & ~(size_bytes-1).
  - An illegal size is executed as a word access.
  - rsp_err is tied to 0.

## Structure
- Shared package mips_cpu_pkg holds:
  - the mem_size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD);
  - the mem_port_state_t enum (IDLE, REQ, RESP).
- One combinational sub-module, mips_cpu_mem_lane, handles byteenable generation, write steering and read extract/extend. It is instantiated once; the FSM lives in the top module.

## Test plan
1. DATA_W=32, store word to 0x1000 with data 0xDEADBEEF, waitrequest=0 -> N+1: write=1, address=0x1000, byteenable=4'b1111, writedata=0xDEADBEEF; N+2: rsp_valid=1, rsp_err=0.
2. Store byte to 0x1003 with data 0x000000A5 -> byteenable=4'b1000, writedata[31:24]=0xA5.
3. Load half at 0x2002 with readdata=0x80011234 -> byteenable=4'b1100; signed: rsp_rdata=0xFFFF8001; unsigned: rsp_rdata=0x00008001.
4. Load word at 0x3000 with waitrequest high for 3 cycles -> read held with address stable for 4 cycles; rsp_valid at N+6; back-to-back request accepted in that same cycle.
5. Load word at 0x2001 -> with the macro: no read, rsp_valid=1 and rsp_err=1 at N+1; without the macro: address=0x2000, byteenable=4'b1111.
6. reset asserted in REQ while waitrequest=1 -> read=0 next cycle, no rsp_valid ever, req_ready=1 in the first cycle after reset deasserts.
